// File: rtl/cpu_pkg.sv
// Shared CPU pipeline types and constants.
// Holds inter-stage bundles, immediate-format encodings and the PC register alias.
package cpu_pkg;

  localparam int XLEN = 32;
  localparam logic [3:0] REG_PC = 4'd15;

  typedef enum logic [1:0] {
    IMM_8    = 2'b00,
    IMM_12   = 2'b01,
    IMM_BR   = 2'b10,
    IMM_NONE = 2'b11
  } imm_src_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc_plus8;
  } fetch_decode_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc_plus8;
    logic            valid;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] ext_imm;
    logic [3:0]      ra1;
    logic [3:0]      ra2;
  } decode_execute_t;

endpackage

// File: rtl/reg_file.sv
// Architectural register file: R0..R(NREGS-1) stored, R15 reads the supplied PC+8.
// Two combinational read ports with write-through bypass, one write port.
module reg_file
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREGS = 15
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [3:0]       A1,
  input  logic [3:0]       A2,
  input  logic [3:0]       A3,
  input  logic             WE3,
  input  logic [WIDTH-1:0] WD3,
  input  logic [WIDTH-1:0] R15,
  output logic [WIDTH-1:0] RD1,
  output logic [WIDTH-1:0] RD2
);

  logic [WIDTH-1:0] regs_reg [NREGS];
  logic [WIDTH-1:0] rd_view  [16];

  for (genvar gi = 0; gi < NREGS; gi++) begin : g_regs
    always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
        regs_reg[gi] <= '0;
      end else if (WE3 && (A3 == 4'(gi))) begin
        regs_reg[gi] <= WD3;
      end
    end
  end

  // Full 16-entry read view so the address can index it without range checks.
  for (genvar gi = 0; gi < 16; gi++) begin : g_view
    if (gi == 15) begin : g_pc
      assign rd_view[gi] = R15;
    end else if (gi < NREGS) begin : g_reg
      assign rd_view[gi] = regs_reg[gi];
    end else begin : g_none
      assign rd_view[gi] = '0;
    end
  end

  // PC read wins over bypass; bypass wins over stored value.
  assign RD1 = ((A1 != REG_PC) && WE3 && (A3 == A1)) ? WD3 : rd_view[A1];
  assign RD2 = ((A2 != REG_PC) && WE3 && (A3 == A2)) ? WD3 : rd_view[A2];

endmodule

// File: rtl/decode_stage.sv
// Decode stage: IF/ID pipeline register with stall/flush, register file reads
// and immediate extension feeding the execute stage.
module decode_stage
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREGS = 15
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] InstrF,
  input  logic [WIDTH-1:0] PCPlus8F,
  input  logic             StallD,
  input  logic             FlushD,
  input  logic [1:0]       RegSrc,
  input  logic [1:0]       ImmSrc,
  input  logic             WE3,
  input  logic [3:0]       A3,
  input  logic [WIDTH-1:0] WD3,
  output logic [WIDTH-1:0] InstrD,
  output logic [WIDTH-1:0] PCPlus8D,
  output logic             ValidD,
  output logic [3:0]       RA1D,
  output logic [3:0]       RA2D,
  output logic [WIDTH-1:0] RD1,
  output logic [WIDTH-1:0] RD2,
  output logic [WIDTH-1:0] ExtImm
);

  logic [WIDTH-1:0] instr_reg;
  logic [WIDTH-1:0] pc_plus8_reg;
  logic             valid_reg;

  // Flush beats stall so a squashed slot never survives a held pipeline.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      instr_reg    <= '0;
      pc_plus8_reg <= '0;
      valid_reg    <= 1'b0;
    end else if (FlushD) begin
      instr_reg    <= '0;
      pc_plus8_reg <= '0;
      valid_reg    <= 1'b0;
    end else if (!StallD) begin
      instr_reg    <= InstrF;
      pc_plus8_reg <= PCPlus8F;
      valid_reg    <= 1'b1;
    end
  end

  assign InstrD   = instr_reg;
  assign PCPlus8D = pc_plus8_reg;
  assign ValidD   = valid_reg;

  assign RA1D = RegSrc[0] ? REG_PC : instr_reg[19:16];
  assign RA2D = RegSrc[1] ? instr_reg[15:12] : instr_reg[3:0];

  reg_file #(
    .WIDTH(WIDTH),
    .NREGS(NREGS)
  ) u_reg_file (
    .CLK (CLK),
    .RST (RST),
    .A1  (RA1D),
    .A2  (RA2D),
    .A3  (A3),
    .WE3 (WE3),
    .WD3 (WD3),
    .R15 (pc_plus8_reg),
    .RD1 (RD1),
    .RD2 (RD2)
  );

  always_comb begin
    ExtImm = '0;
    case (imm_src_e'(ImmSrc))
      IMM_8:    ExtImm = {{(WIDTH-8){1'b0}}, instr_reg[7:0]};
      IMM_12:   ExtImm = {{(WIDTH-12){1'b0}}, instr_reg[11:0]};
      IMM_BR:   ExtImm = {{(WIDTH-26){instr_reg[23]}}, instr_reg[23:0], 2'b00};
      IMM_NONE: ExtImm = '0;
      default:  ExtImm = '0;
    endcase
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
Decode stage directly downstream of the fetch stage. It consumes the fetched instruction and PC+8 (R15 value), and holds them in the IF/ID pipeline register, which supports stall and flush. It contains the 15-entry architectural register file with a writeback port and write-through bypass, and the immediate extender. It produces operand values, extended immediate, source register numbers for the hazard unit, and a valid flag for the execute stage.

Parameters:
WIDTH, 32, datapath width (instruction, PC, register data)
NREGS, 15, number of physical registers R0..R14; R15 is never stored

Ports:
CLK  in  1  clock; all state updates on rising edge
RST  in  1  asynchronous active-low reset
InstrF  in  32  instruction from fetch
PCPlus8F  in  32  PC+8 from fetch (R15 read value)
StallD  in  1  hold IF/ID contents
FlushD  in  1  insert bubble into IF/ID
RegSrc  in  2  operand address select from control
ImmSrc  in  2  immediate format select from control
WE3  in  1  writeback register write enable
A3  in  4  writeback destination register
WD3  in  32  writeback data
InstrD  out  32  registered instruction
PCPlus8D  out  32  registered PC+8
ValidD  out  1  1 = InstrD is a real instruction, 0 = bubble
RA1D  out  4  source register 1 number (for hazard unit)
RA2D  out  4  source register 2 number
RD1  out  32  operand 1
RD2  out  32  operand 2
ExtImm  out  32  extended immediate

Behaviour:
- Reset (RST=0, asynchronous, immediate): InstrD=0, PCPlus8D=0, ValidD=0, R0..R14=0. Combinational outputs then follow from these values: RA1D=0, RA2D=0, RD1=0, RD2=0 (unless a bypass is active), ExtImm=0. Reset asserted mid-operation aborts any pending write. The first capture occurs on the first rising edge after RST deasserts.
- IF/ID register, priority per rising edge:
  - FlushD=1: InstrD<=0, PCPlus8D<=0, ValidD<=0. FlushD beats StallD when both are high.
  - Else StallD=1: all fields hold.
  - Else: InstrD<=InstrF, PCPlus8D<=PCPlus8F, ValidD<=1.
- Latency: InstrF appears on InstrD one cycle after capture. RD1, RD2, ExtImm, RA1D and RA2D are combinational from InstrD and the register file (zero added cycles).
- Address select:
  - RA1D = RegSrc[0] ? 4'd15 : InstrD[19:16]
  - RA2D = RegSrc[1] ? InstrD[15:12] : InstrD[3:0]
- Read, priority order per port:
  - RA==15: return PCPlus8D.
  - Else WE3=1 and A3==RA: return WD3 (write-through bypass, same cycle).
  - Else: return stored register.
- Write: on a rising edge with WE3=1 and A3!=15, write WD3 into reg[A3].
  - A3==15 is silently ignored; the PC is updated through the fetch path.
  - Writes are independent of StallD, FlushD and ValidD.
- Extend (from InstrD):
  - ImmSrc 00: zero-extend [7:0]
  - ImmSrc 01: zero-extend [11:0]
  - ImmSrc 10: sign-extend {[23:0],2'b00} to 32 bits
  - ImmSrc 11: 0
- Bubbles (ValidD=0) still drive deterministic outputs, since InstrD=0. Gating of side effects on bubbles is done downstream using ValidD.
- Two reads of the same register, and reads of the register being written, return identical bypassed data.

Decomposition:
- Shared package (cpu_pkg, alongside fetch_decode_t):
  - decode_execute_t carrying InstrD, PCPlus8D, ValidD, RD1, RD2, ExtImm, RA1D, RA2D
  - ImmSrc encodings IMM_8, IMM_12, IMM_BR, IMM_NONE
  - constant REG_PC=4'd15
- Sub-module reg_file: 2 read ports, 1 write port, R15 override, bypass, async active-low reset.
- Pipeline register and extend logic stay in decode_stage.

Test Plan:
- Reset: drive RST=0 with InstrF=0xE3A01005 and clock -> InstrD=0, ValidD=0, RD1=RD2=0. Release RST and clock once -> InstrD=0xE3A01005, ValidD=1.
- Write then read: WE3=1, A3=3, WD3=0xDEADBEEF, one edge; then InstrD[3:0]=3, RegSrc=00 -> RD2=0xDEADBEEF.
- Bypass: reg R2=0x11; same cycle WE3=1, A3=2, WD3=0x22 with RA1D=2 -> RD1=0x22 before the edge, and 0x22 held after it.
- R15: RegSrc[0]=1, PCPlus8D=0x108 -> RA1D=15, RD1=0x108. WE3=1, A3=15, WD3=0x5 -> no register changes, RD1 stays 0x108.
- Stall/flush: StallD=1 for 2 cycles -> InstrD holds. StallD=1 and FlushD=1 together -> InstrD=0, ValidD=0.
- Extend: InstrD[23:0]=0xFFFFFE, ImmSrc=10 -> ExtImm=0xFFFFFFF8. InstrD[11:0]=0xABC, ImmSrc=01 -> 0x00000ABC. ImmSrc=00 -> 0x000000BC.
